// File: rtl/hamming_pkg.sv
// Shared types and constants for the SECDED Hamming(16,11) decode path.
package hamming_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_L,
    RD_M,
    CAP,
    FIX,
    WR_L,
    WR_M,
    DONE
  } state_t;

  typedef logic [1:0] err_flag_t;

  localparam err_flag_t FLAG_CLEAN  = 2'b00;
  localparam err_flag_t FLAG_SINGLE = 2'b01;
  localparam err_flag_t FLAG_DOUBLE = 2'b10;

  // Syndrome bit b is the parity of every codeword position whose index has bit b set.
  localparam logic [3:0][15:0] SYN_MASK = {16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA};

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hamming_syndrome_calc.sv
// Combinational SECDED check/correct for one 16-bit codeword.
module hamming_syndrome_calc
  import hamming_pkg::*;
(
  input  logic [7:0]  lsw_i,
  input  logic [7:0]  msw_i,
  output logic [3:0]  syndrome_o,
  output logic        parity_o,
  output logic [15:0] corrected_o,
  output err_flag_t   flag_o
);

  logic [15:0] word;
  assign word = {msw_i, lsw_i};

  // One XOR tree per syndrome bit
  for (genvar gi = 0; gi < 4; gi++) begin : g_syn
    assign syndrome_o[gi] = ^(word & SYN_MASK[gi]);
  end

  assign parity_o = ^word;

  // Odd overall parity means exactly one flip, located by the syndrome (0 = p0 itself)
  always_comb begin
    corrected_o = word;
    flag_o      = FLAG_CLEAN;
    if (parity_o) begin
      corrected_o[syndrome_o] = ~word[syndrome_o];
      flag_o                  = FLAG_SINGLE;
    end else if (syndrome_o != 4'd0) begin
      flag_o = FLAG_DOUBLE;
    end
  end

endmodule

// File: rtl/hamming_decode_ctrl.sv
// Decode-pass sequencer: reads encoded words, corrects them and writes data + flag back.
module hamming_decode_ctrl
  import hamming_pkg::*;
#(
  parameter int N_WORDS  = 15,
  parameter int SRC_BASE = 30,
  parameter int DST_BASE = 0,
  parameter int ADDR_W   = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  output logic [7:0]        err1_cnt,
  output logic [7:0]        err2_cnt
);

  localparam int                IDX_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_WORDS - 1);
  localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [7:0]        lsw_q;
  logic [7:0]        msw_q;
  logic [7:0]        msw_out_q;
  logic [7:0]        mem_wr_data_q;
  logic [7:0]        err1_q;
  logic [7:0]        err2_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              busy_q;
  logic              done_q;
  logic              mem_wr_en_q;

  logic [IDX_W-1:0]  idx_d;
  logic [ADDR_W-1:0] src_cur;
  logic [ADDR_W-1:0] src_nxt;
  logic [ADDR_W-1:0] dst_cur;
  logic [7:0]        lsw_out_d;
  logic [7:0]        msw_out_d;

  logic [3:0]        syn;
  logic              par;
  logic [15:0]       corr;
  err_flag_t         flag;

  hamming_syndrome_calc u_syn (
    .lsw_i       (lsw_q),
    .msw_i       (msw_q),
    .syndrome_o  (syn),
    .parity_o    (par),
    .corrected_o (corr),
    .flag_o      (flag)
  );

  // Word addresses wrap naturally at 2^ADDR_W.
  assign idx_d   = idx_q + IDX_W'(1);
  assign src_cur = SRC_A + (ADDR_W'(idx_q) << 1);
  assign src_nxt = SRC_A + (ADDR_W'(idx_d) << 1);
  assign dst_cur = DST_A + (ADDR_W'(idx_q) << 1);

  // Data bits b8..b1 and b11..b9 pulled out of the corrected word; flag rides in the top bits.
  assign lsw_out_d = {corr[12:9], corr[7:5], corr[3]};
  assign msw_out_d = {flag, 3'b000, corr[15:13]};

  // Parity bits and the raw syndrome are consumed only through the flag.
  logic unused_bits;
  assign unused_bits = ^{syn, par, corr[8], corr[4], corr[2:0]};

  // Sequencer: one state per memory beat, every output registered on the transition into its state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      lsw_q         <= '0;
      msw_q         <= '0;
      msw_out_q     <= '0;
      mem_wr_data_q <= '0;
      err1_q        <= '0;
      err2_q        <= '0;
      mem_addr_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_wr_en_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= RD_L;
            idx_q      <= '0;
            err1_q     <= '0;
            err2_q     <= '0;
            busy_q     <= 1'b1;
            mem_addr_q <= SRC_A;
          end
        end
        RD_L: begin
          mem_addr_q <= src_cur + ONE_A;
          state_q    <= RD_M;
        end
        RD_M: begin
          lsw_q   <= mem_rd_data;
          state_q <= CAP;
        end
        CAP: begin
          msw_q   <= mem_rd_data;
          state_q <= FIX;
        end
        FIX: begin
          msw_out_q     <= msw_out_d;
          mem_wr_data_q <= lsw_out_d;
          mem_wr_en_q   <= 1'b1;
          mem_addr_q    <= dst_cur;
          if (flag == FLAG_SINGLE) err1_q <= sat_inc(err1_q);
          if (flag == FLAG_DOUBLE) err2_q <= sat_inc(err2_q);
          state_q <= WR_L;
        end
        WR_L: begin
          mem_addr_q    <= dst_cur + ONE_A;
          mem_wr_data_q <= msw_out_q;
          state_q       <= WR_M;
        end
        WR_M: begin
          mem_wr_en_q   <= 1'b0;
          mem_wr_data_q <= '0;
          if (idx_q == LAST_IDX) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            mem_addr_q <= '0;
          end else begin
            idx_q      <= idx_d;
            mem_addr_q <= src_nxt;
            state_q    <= RD_L;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_data = mem_wr_data_q;
  assign err1_cnt    = err1_q;
  assign err2_cnt    = err2_q;

endmodule
